julia_frame_reader: RTL and testbench
=====================================

JULIA_FRAME_READER -- requirements
Module: julia_frame_reader

Interface
REQ-001 SHALL have parameter ADDRESSWIDTH, default 32: width of the Avalon master address.
REQ-002 SHALL have parameter DATAWIDTH, default 32: width of the read data and output data.
REQ-003 SHALL have parameter BASE_ADDR, default 32'h08000000: SDRAM byte address of the first pixel word.
REQ-004 SHALL have parameter NUM_WORDS, default 307200: number of words read per frame.
REQ-005 SHALL have parameter FIFO_DEPTH, default 16: number of elastic buffer entries, a power of 2.
REQ-006 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-007 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-008 SHALL have port start, input, 1 bit: one-cycle pulse that begins a frame read.
REQ-009 SHALL have port busy, output, 1 bit: high from frame acceptance until done.
REQ-010 SHALL have port done, output, 1 bit: one-cycle pulse after the last word has been delivered.
REQ-011 SHALL have port master_address, output, ADDRESSWIDTH bits: byte address of the read.
REQ-012 SHALL have port master_read, output, 1 bit: Avalon read request.
REQ-013 SHALL have port master_waitrequest, input, 1 bit: slave stall.
REQ-014 SHALL have port master_readdata, input, DATAWIDTH bits: returned data.
REQ-015 SHALL have port master_readdatavalid, input, 1 bit: qualifies master_readdata.
REQ-016 SHALL have port out_data, output, DATAWIDTH bits: stream data.
REQ-017 SHALL have port out_valid, output, 1 bit: stream valid.
REQ-018 SHALL have port out_ready, input, 1 bit: downstream accept.

Function
REQ-019 SHALL implement FSM states IDLE, READ, DRAIN, DONE.
REQ-020 IDLE: on start=1, SHALL load the address register with BASE_ADDR, clear all counters and the FIFO, and go to READ.
REQ-021 READ: SHALL assert master_read when issued < NUM_WORDS and pending + fifo_count < FIFO_DEPTH (credit rule).
REQ-022 A read SHALL be accepted in a cycle where master_read=1 and master_waitrequest=0; on acceptance the address SHALL advance by 4, issued SHALL increment by 1, and pending SHALL increment by 1.
REQ-023 While master_waitrequest=1, master_read and master_address SHALL hold stable.
REQ-024 Once master_read is asserted, it SHALL NOT deassert before acceptance.
REQ-025 When issued reaches NUM_WORDS after an accepted read, the FSM SHALL go to DRAIN.
REQ-026 On master_readdatavalid=1, master_readdata SHALL be written to the FIFO and pending SHALL decrement by 1.
REQ-027 Read data SHALL be accepted in any state other than IDLE, including in the same cycle as an acceptance (pending is unchanged then).
REQ-028 The credit rule SHALL guarantee that the FIFO never overflows; readdatavalid is never back-pressured.
REQ-029 out_valid SHALL equal fifo not-empty, and out_data SHALL equal the FIFO head.
REQ-030 A word SHALL pop when out_valid=1 and out_ready=1, and delivered SHALL increment by 1.
REQ-031 A FIFO push and pop in the same cycle SHALL leave fifo_count unchanged.
REQ-032 A push to an empty FIFO SHALL become visible on out_valid in the next cycle (1-cycle latency).
REQ-033 DRAIN: when delivered reaches NUM_WORDS, the FSM SHALL go to DONE.
REQ-034 DONE: the block SHALL assert done for exactly one cycle and return to IDLE.
REQ-035 busy SHALL be 1 in READ and DRAIN, and 0 in IDLE and DONE.
REQ-036 start SHALL be ignored in READ, DRAIN and DONE.
REQ-037 Words SHALL be delivered in ascending address order with none dropped or duplicated.
REQ-038 Counters SHALL be wide enough for NUM_WORDS; the address SHALL wrap modulo 2^ADDRESSWIDTH without error.

Reset
REQ-039 When reset=1 at a clock edge, the FSM SHALL enter IDLE, and the FIFO, pending, issued and delivered SHALL all clear to 0.
REQ-040 During and after reset: master_read=0, master_address=BASE_ADDR, out_valid=0, out_data=0, busy=0, done=0.
REQ-041 A reset mid-frame SHALL abandon the frame, and read data returning after reset SHALL be ignored.

Verification
REQ-042 NUM_WORDS=8, waitrequest=0, readdatavalid 1 cycle after acceptance, out_ready=1 -> addresses 0x08000000..0x0800001C, 8 words out in order, a single done pulse, busy low afterwards.
REQ-043 out_ready=0 throughout, NUM_WORDS=64, FIFO_DEPTH=16 -> exactly 16 reads issued and master_read deasserted; after out_ready=1 all 64 words delivered with no loss.
REQ-044 waitrequest=1 for 5 cycles on the 3rd read -> master_read and address 0x08000008 stable for all 5 cycles, issued not incremented.
REQ-045 Simultaneous readdatavalid and out_ready with fifo_count=3 -> fifo_count remains 3 and data ordering is preserved.
REQ-046 start pulsed during READ -> ignored, the frame completes normally with one done pulse.
REQ-047 reset asserted with 4 reads pending, then a new start -> post-reset stale readdatavalid dropped, the new frame delivers words from BASE_ADDR only.

Source files
------------

// File: rtl/julia_frame_reader.sv
`default_nettype none
// ============================================================================
// Module      : julia_frame_reader
// Description : Streams a frame of NUM_WORDS pixel words from SDRAM over an
//               Avalon read master into a valid/ready stream via a FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
module julia_frame_reader #(
    parameter int                      ADDRESSWIDTH = 32,
    parameter int                      DATAWIDTH    = 32,
    parameter logic [ADDRESSWIDTH-1:0] BASE_ADDR    = 32'h0800_0000,
    parameter int                      NUM_WORDS    = 307200,
    parameter int                      FIFO_DEPTH   = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    output logic                    busy,
    output logic                    done,
    output logic [ADDRESSWIDTH-1:0] master_address,
    output logic                    master_read,
    input  logic                    master_waitrequest,
    input  logic [DATAWIDTH-1:0]    master_readdata,
    input  logic                    master_readdatavalid,
    output logic [DATAWIDTH-1:0]    out_data,
    output logic                    out_valid,
    input  logic                    out_ready
);

    localparam int CNT_W  = $clog2(NUM_WORDS + 1);
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int FCNT_W = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                  r_state;
    logic [ADDRESSWIDTH-1:0] r_addr;
    logic [CNT_W-1:0]        r_issued;
    logic [CNT_W-1:0]        r_delivered;
    logic [FCNT_W-1:0]       r_pending;
    logic [FCNT_W-1:0]       r_count;
    logic [PTR_W-1:0]        r_wr_ptr;
    logic [PTR_W-1:0]        r_rd_ptr;
    logic [DATAWIDTH-1:0]    r_mem [FIFO_DEPTH];

    logic w_credit;
    logic w_read;
    logic w_accept;
    logic w_push;
    logic w_pop;

    // Outstanding reads plus buffered words never exceed the FIFO size, so
    // returning data always has a slot. The sum stays constant or shrinks
    // while a request is stalled, so master_read cannot drop before acceptance.
    assign w_credit = ({1'b0, r_pending} + {1'b0, r_count}) < (FCNT_W + 1)'(FIFO_DEPTH);
    assign w_read   = (r_state == S_READ) && (r_issued < CNT_W'(NUM_WORDS)) && w_credit;
    assign w_accept = w_read && !master_waitrequest;
    // Data with no matching request (e.g. stale returns) is discarded.
    assign w_push   = master_readdatavalid && (r_state != S_IDLE) && (r_pending != '0);
    assign w_pop    = (r_count != '0) && out_ready;

    assign master_read    = w_read;
    assign master_address = r_addr;
    assign out_valid      = (r_count != '0);
    assign out_data       = (r_count != '0) ? r_mem[r_rd_ptr] : '0;
    assign busy           = (r_state == S_READ) || (r_state == S_DRAIN);
    assign done           = (r_state == S_DONE);

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= master_readdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_addr      <= BASE_ADDR;
            r_issued    <= '0;
            r_delivered <= '0;
            r_pending   <= '0;
            r_count     <= '0;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
        end else if (r_state == S_IDLE) begin
            if (start) begin
                r_state     <= S_READ;
                r_addr      <= BASE_ADDR;
                r_issued    <= '0;
                r_delivered <= '0;
                r_pending   <= '0;
                r_count     <= '0;
                r_wr_ptr    <= '0;
                r_rd_ptr    <= '0;
            end
        end else begin
            case (r_state)
                S_READ: begin
                    if (w_accept && (r_issued == CNT_W'(NUM_WORDS - 1))) begin
                        r_state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (r_delivered == CNT_W'(NUM_WORDS)) begin
                        r_state <= S_DONE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase

            if (w_accept) begin
                r_addr   <= r_addr + ADDRESSWIDTH'(4);
                r_issued <= r_issued + CNT_W'(1);
            end

            case ({w_accept, w_push})
                2'b10:   r_pending <= r_pending + FCNT_W'(1);
                2'b01:   r_pending <= r_pending - FCNT_W'(1);
                default: r_pending <= r_pending;
            endcase

            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + FCNT_W'(1);
                2'b01:   r_count <= r_count - FCNT_W'(1);
                default: r_count <= r_count;
            endcase

            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr    <= r_rd_ptr + PTR_W'(1);
                r_delivered <= r_delivered + CNT_W'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_julia_frame_reader.sv
`default_nettype none
// ============================================================================
// Module      : tb_julia_frame_reader
// Description : Scoreboard bench with a randomized Avalon slave model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_julia_frame_reader;

    localparam int          AW   = 32;
    localparam int          DW   = 32;
    localparam int          NW   = 64;
    localparam int          FD   = 16;
    localparam logic [31:0] BASE = 32'h0800_0000;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic          busy;
    logic          done;
    logic [AW-1:0] master_address;
    logic          master_read;
    logic          master_waitrequest = 1'b0;
    logic [DW-1:0] master_readdata = '0;
    logic          master_readdatavalid = 1'b0;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready = 1'b1;

    julia_frame_reader #(
        .ADDRESSWIDTH(AW), .DATAWIDTH(DW), .BASE_ADDR(BASE),
        .NUM_WORDS(NW), .FIFO_DEPTH(FD)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
        .master_address(master_address), .master_read(master_read),
        .master_waitrequest(master_waitrequest), .master_readdata(master_readdata),
        .master_readdatavalid(master_readdatavalid),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        int          due;
    } rsp_t;

    rsp_t        rsp_q[$];
    logic [31:0] exp_q[$];
    int          compared = 0;
    int          mismatched = 0;
    int          cyc = 0;
    int          last_due = 0;
    int          acc_cnt = 0;
    int          done_cnt = 0;
    int          fixed_lat = 1;
    int          rdy_mode = 1;
    int          wr_rand = 0;
    int          stall_en = 0;
    int          stall_left = 0;
    int          stall_checks = 0;
    int          lat;
    int          due;
    logic [31:0] salt = 32'h0;
    logic        rst_q = 1'b1;
    logic        prev_hold = 1'b0;
    logic [31:0] prev_addr = '0;

    function automatic logic [31:0] rdata_f(input logic [31:0] a, input logic [31:0] s);
        return (a * 32'h9E37_79B1) ^ s;
    endfunction

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] req);
        compared++;
        if (act !== req) begin
            mismatched++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic req);
        compared++;
        if (act !== req) begin
            mismatched++;
            $display("FAIL %s: got %b, required %b", name, act, req);
        end
    endtask

    // Slave drive side: returns responses in order, drives waitrequest/out_ready.
    always begin
        @(posedge clk);
        rst_q = reset;
        cyc++;
        #1;
        if (rsp_q.size() > 0 && rsp_q[0].due <= cyc) begin
            master_readdatavalid = 1'b1;
            master_readdata      = rsp_q[0].data;
            void'(rsp_q.pop_front());
        end else begin
            master_readdatavalid = 1'b0;
            master_readdata      = $urandom;
        end
        if (stall_en != 0 && acc_cnt == 2 && stall_left > 0) begin
            master_waitrequest = 1'b1;
            stall_left--;
        end else begin
            master_waitrequest = (wr_rand != 0) ? ($urandom_range(0, 3) == 0) : 1'b0;
        end
        case (rdy_mode)
            0:       out_ready = 1'b0;
            1:       out_ready = 1'b1;
            default: out_ready = 1'($urandom_range(0, 1));
        endcase
    end

    // Monitor: samples on the falling edge what the next rising edge will commit.
    always @(negedge clk) begin
        if (reset || rst_q) begin
            if (rst_q) begin
                check1("rst_read", master_read, 1'b0);
                check32("rst_addr", master_address, BASE);
                check1("rst_valid", out_valid, 1'b0);
                check32("rst_data", out_data, 32'h0);
                check1("rst_busy", busy, 1'b0);
                check1("rst_done", done, 1'b0);
            end
            prev_hold = 1'b0;
        end else begin
            if (prev_hold) begin
                check1("hold_read", master_read, 1'b1);
                check32("hold_addr", master_address, prev_addr);
            end
            prev_hold = master_read && master_waitrequest;
            prev_addr = master_address;
            if (stall_en != 0 && master_waitrequest && acc_cnt == 2) begin
                check1("stall_read", master_read, 1'b1);
                check32("stall_addr", master_address, BASE + 32'h8);
                stall_checks++;
            end
            if (master_read && !master_waitrequest) begin
                check32("acc_addr", master_address, BASE + 32'(acc_cnt) * 32'd4);
                lat = (fixed_lat != 0) ? fixed_lat : int'($urandom_range(1, 4));
                due = cyc + lat;
                if (due <= last_due) due = last_due + 1;
                last_due = due;
                rsp_q.push_back('{rdata_f(master_address, salt), due});
                acc_cnt++;
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("FAIL extra_word: got %h, required no word", out_data);
                end else begin
                    check32("out_data", out_data, exp_q.pop_front());
                end
            end
            if (done) begin
                done_cnt++;
                check1("done_busy", busy, 1'b0);
            end
        end
    end

    task automatic start_frame();
        salt     = $urandom;
        acc_cnt  = 0;
        done_cnt = 0;
        for (int i = 0; i < NW; i++) exp_q.push_back(rdata_f(BASE + 32'(i) * 32'd4, salt));
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string name);
        int c = 0;
        while (done_cnt == 0 && c < budget) begin
            @(posedge clk);
            c++;
        end
        if (done_cnt == 0) begin
            compared++;
            mismatched++;
            $display("FAIL %s_timeout: got no done in %0d cycles, required done", name, budget);
        end
        repeat (4) @(posedge clk);
        @(negedge clk);
        check32({name, "_done_pulses"}, 32'(done_cnt), 32'd1);
        check1({name, "_busy_after"}, busy, 1'b0);
        check32({name, "_words_left"}, 32'(exp_q.size()), 32'd0);
        check32({name, "_reads"}, 32'(acc_cnt), 32'(NW));
        exp_q.delete();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no end of test, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check1("idle_busy", busy, 1'b0);
        check32("idle_addr", master_address, BASE);

        // In-order basic frame, fixed 1-cycle read latency.
        start_frame();
        wait_done(2000, "basic");

        // Downstream stalled: credit limit must cap outstanding reads.
        @(negedge clk);
        rdy_mode  = 0;
        fixed_lat = 0;
        start_frame();
        repeat (60) @(posedge clk);
        @(negedge clk);
        check32("credit_reads", 32'(acc_cnt), 32'(FD));
        check1("credit_read_low", master_read, 1'b0);
        check1("credit_valid", out_valid, 1'b1);
        rdy_mode = 1;
        wait_done(2000, "backpressure");

        // Five-cycle waitrequest on the third read.
        @(negedge clk);
        fixed_lat    = 1;
        stall_en     = 1;
        stall_left   = 5;
        stall_checks = 0;
        start_frame();
        wait_done(2000, "stall");
        check32("stall_cycles", 32'(stall_checks), 32'd5);
        stall_en = 0;

        // Random traffic with a spurious start mid-frame.
        @(negedge clk);
        wr_rand   = 1;
        fixed_lat = 0;
        rdy_mode  = 2;
        start_frame();
        repeat (20) @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        wait_done(4000, "start_ignored");

        // Reset with reads outstanding; stale returns must be dropped.
        @(negedge clk);
        wr_rand   = 0;
        rdy_mode  = 1;
        fixed_lat = 8;
        start_frame();
        for (int c = 0; c < 50 && rsp_q.size() < 4; c++) @(posedge clk);
        check1("pending_reached", rsp_q.size() >= 4, 1'b1);
        #1 reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        exp_q.delete();
        for (int c = 0; c < 100 && rsp_q.size() > 0; c++) @(posedge clk);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check1("stale_dropped", out_valid, 1'b0);
        check1("stale_busy", busy, 1'b0);
        fixed_lat = 0;
        wr_rand   = 1;
        rdy_mode  = 2;
        start_frame();
        wait_done(4000, "after_reset");

        for (int f = 0; f < 2; f++) begin
            @(negedge clk);
            start_frame();
            wait_done(4000, "random");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
`default_nettype wire
